keccak_padder_multi: RTL and testbench

- Parametrised successor to the fixed SHA3-512 input padder.
- Absorbs message words of configurable width into a rate-wide block and applies SHA-3 or legacy Keccak multi-rate padding.
- Rate is selected at run time for SHA3-224/256/384/512.
- Hands each completed block to the permutation core with an out_ready/f_ack handshake; sits between the host word interface and the f_permutation.

---
 rtl/keccak_padder_multi_if.sv | 42 ++++
 rtl/keccak_padder_multi.sv | 140 ++++++++++++++
 tb/tb_keccak_padder_multi.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_padder_multi_if.sv
// Word/block interface between the host, the padder and the permutation core.
//   master : host + permutation side (drives words, mode, f_ack)
//   slave  : padder side (drives out, out_ready, buffer_full, rate_sel)
// Signals:
//   mode[1:0]        rate select (0=1152, 1=1088, 2=832, 3=576)
//   keccak_mode      0: SHA-3 domain byte 0x06, 1: legacy Keccak 0x01
//   in[IN_W-1:0]     message word, first byte in the top byte lane
//   in_ready         in is valid this cycle
//   is_last          final word of the message
//   byte_num         valid bytes in the final word
//   buffer_full      block complete, words not accepted
//   out[MAX_RATE-1:0] padded block, left-aligned
//   out_ready        out holds a valid block
//   f_ack            permutation has taken the block
//   rate_sel[1:0]    mode latched for the current message
interface keccak_padder_multi_if #(
  parameter int IN_W     = 32,
  parameter int BN_W     = 2,
  parameter int MAX_RATE = 1152
) ();
  logic [1:0]          mode;
  logic                keccak_mode;
  logic [IN_W-1:0]     in;
  logic                in_ready;
  logic                is_last;
  logic [BN_W-1:0]     byte_num;
  logic                buffer_full;
  logic [MAX_RATE-1:0] out;
  logic                out_ready;
  logic                f_ack;
  logic [1:0]          rate_sel;

  modport master (
    output mode, keccak_mode, in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready, rate_sel
  );

  modport slave (
    input  mode, keccak_mode, in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready, rate_sel
  );
endinterface

// File: rtl/keccak_padder_multi.sv
// Multi-rate SHA-3 / legacy Keccak input padder.
// Packs IN_W-bit message words into a left-aligned rate-wide block, applies
// the domain byte plus the final 0x80 bit on the last word, and hands each
// completed block to the permutation with an out_ready/f_ack handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    keccak_padder_multi_if slave modport (see interface header)
module keccak_padder_multi #(
  parameter int IN_W     = 32,
  parameter int BN_W     = 2,
  parameter int MAX_RATE = 1152
) (
  input logic                 clk,
  input logic                 reset,
  keccak_padder_multi_if.slave bus
);
  localparam int NB    = IN_W / 8;
  localparam int SLOTS = MAX_RATE / IN_W;
  localparam int RATE0 = 1152;
  localparam int RATE1 = 1088;
  localparam int RATE2 = 832;
  localparam int RATE3 = 576;

  typedef enum logic [1:0] {ABSORB, WAIT_ACK, DONE} state_t;

  state_t              state_reg;
  logic [5:0]          cnt_reg;
  logic                pad_done_reg;
  logic                latched_reg;
  logic                out_ready_reg;
  logic                buffer_full_reg;
  logic [1:0]          rate_sel_reg;
  logic [MAX_RATE-1:0] out_reg;

  logic [MAX_RATE-1:0] absorb_next;
  logic [1:0]          eff_mode;
  logic [5:0]          last_slot;
  logic [7:0]          domain_byte;
  logic [IN_W-1:0]     last_word;

  // The very first accepted word must already use the incoming mode, since
  // rate_sel is only latched on that same edge (matters for 1-word messages).
  assign eff_mode    = latched_reg ? rate_sel_reg : bus.mode;
  assign domain_byte = bus.keccak_mode ? 8'h01 : 8'h06;

  always_comb begin
    case (eff_mode)
      2'd0:    last_slot = 6'(RATE0 / IN_W - 1);
      2'd1:    last_slot = 6'(RATE1 / IN_W - 1);
      2'd2:    last_slot = 6'(RATE2 / IN_W - 1);
      default: last_slot = 6'(RATE3 / IN_W - 1);
    endcase
  end

  // Final word: valid bytes, then the domain byte, then zeros.
  for (genvar gi = 0; gi < NB; gi++) begin : g_last_byte
    localparam int HI = IN_W - 1 - gi * 8;
    assign last_word[HI -: 8] =
      (BN_W'(gi) <  bus.byte_num) ? bus.in[HI -: 8] :
      (BN_W'(gi) == bus.byte_num) ? domain_byte     : 8'h00;
  end

  // Block contents after accepting the presented word in slot cnt_reg.
  always_comb begin
    absorb_next = out_reg;
    for (int s = 0; s < SLOTS; s++) begin
      if (s == int'(cnt_reg))
        absorb_next[MAX_RATE-1-s*IN_W -: IN_W] = bus.is_last ? last_word : bus.in;
      else if (bus.is_last && s > int'(cnt_reg))
        absorb_next[MAX_RATE-1-s*IN_W -: IN_W] = '0;
    end
    // Closing pad bit lives in the last byte of the rate; it may land in the
    // same byte as the domain byte (0x86 / 0x81).
    if (bus.is_last) begin
      case (eff_mode)
        2'd0:    absorb_next[MAX_RATE-RATE0 +: 8] = absorb_next[MAX_RATE-RATE0 +: 8] | 8'h80;
        2'd1:    absorb_next[MAX_RATE-RATE1 +: 8] = absorb_next[MAX_RATE-RATE1 +: 8] | 8'h80;
        2'd2:    absorb_next[MAX_RATE-RATE2 +: 8] = absorb_next[MAX_RATE-RATE2 +: 8] | 8'h80;
        default: absorb_next[MAX_RATE-RATE3 +: 8] = absorb_next[MAX_RATE-RATE3 +: 8] | 8'h80;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ABSORB;
      cnt_reg         <= '0;
      pad_done_reg    <= 1'b0;
      latched_reg     <= 1'b0;
      out_ready_reg   <= 1'b0;
      buffer_full_reg <= 1'b0;
      rate_sel_reg    <= 2'd0;
      out_reg         <= '0;
    end else begin
      case (state_reg)
        ABSORB: begin
          if (bus.in_ready && !buffer_full_reg) begin
            out_reg <= absorb_next;
            if (!latched_reg) begin
              rate_sel_reg <= bus.mode;
              latched_reg  <= 1'b1;
            end
            if (bus.is_last) begin
              pad_done_reg    <= 1'b1;
              state_reg       <= WAIT_ACK;
              out_ready_reg   <= 1'b1;
              buffer_full_reg <= 1'b1;
            end else if (cnt_reg == last_slot) begin
              state_reg       <= WAIT_ACK;
              out_ready_reg   <= 1'b1;
              buffer_full_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 6'd1;
            end
          end
        end
        WAIT_ACK: begin
          // Words offered here (even alongside f_ack) are dropped.
          if (bus.f_ack) begin
            out_reg         <= '0;
            cnt_reg         <= '0;
            out_ready_reg   <= 1'b0;
            buffer_full_reg <= 1'b0;
            state_reg       <= pad_done_reg ? DONE : ABSORB;
          end
        end
        DONE: begin
          // Terminal until reset.
        end
        default: state_reg <= ABSORB;
      endcase
    end
  end

  assign bus.out         = out_reg;
  assign bus.out_ready   = out_ready_reg;
  assign bus.buffer_full = buffer_full_reg;
  assign bus.rate_sel    = rate_sel_reg;
endmodule

// File: tb/tb_keccak_padder_multi.sv
module tb_keccak_padder_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic sel64;
  logic [1:0]  mode_v;
  logic        kmode_v;
  logic [63:0] word_v;
  logic        in_ready_v, is_last_v, f_ack_v;
  logic [2:0]  bn_v;

  int total = 0;
  int bad   = 0;

  logic [7:0] msg_q[$];
  logic [7:0] pad_q[$];

  keccak_padder_multi_if #(.IN_W(32), .BN_W(2), .MAX_RATE(1152)) if32();
  keccak_padder_multi_if #(.IN_W(64), .BN_W(3), .MAX_RATE(1152)) if64();

  keccak_padder_multi #(.IN_W(32), .BN_W(2), .MAX_RATE(1152)) u32 (
    .clk(clk), .reset(reset), .bus(if32));
  keccak_padder_multi #(.IN_W(64), .BN_W(3), .MAX_RATE(1152)) u64 (
    .clk(clk), .reset(reset), .bus(if64));

  assign if32.mode        = mode_v;
  assign if32.keccak_mode = kmode_v;
  assign if32.in          = word_v[63:32];
  assign if32.in_ready    = in_ready_v & ~sel64;
  assign if32.is_last     = is_last_v;
  assign if32.byte_num    = bn_v[1:0];
  assign if32.f_ack       = f_ack_v & ~sel64;

  assign if64.mode        = mode_v;
  assign if64.keccak_mode = kmode_v;
  assign if64.in          = word_v;
  assign if64.in_ready    = in_ready_v & sel64;
  assign if64.is_last     = is_last_v;
  assign if64.byte_num    = bn_v;
  assign if64.f_ack       = f_ack_v & sel64;

  logic [1151:0] out_o;
  logic          out_ready_o, buffer_full_o;
  logic [1:0]    rate_sel_o;
  always_comb begin
    out_o         = sel64 ? if64.out         : if32.out;
    out_ready_o   = sel64 ? if64.out_ready   : if32.out_ready;
    buffer_full_o = sel64 ? if64.buffer_full : if32.buffer_full;
    rate_sel_o    = sel64 ? if64.rate_sel    : if32.rate_sel;
  end

  task automatic chk(input string tag, input logic [1151:0] obs, input logic [1151:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rate_bytes(input logic [1:0] m);
    case (m)
      2'd0:    return 144;
      2'd1:    return 136;
      2'd2:    return 104;
      default: return 72;
    endcase
  endfunction

  // Reference: byte-stream pad10*1 with the domain byte, split into rate blocks.
  task automatic build_pad(input logic kmode, input int r);
    pad_q = msg_q;
    pad_q.push_back(kmode ? 8'h01 : 8'h06);
    while ((pad_q.size() % r) != 0) pad_q.push_back(8'h00);
    pad_q[pad_q.size()-1] = pad_q[pad_q.size()-1] | 8'h80;
  endtask

  function automatic logic [1151:0] exp_block(input int b, input int r);
    logic [1151:0] e;
    e = '0;
    for (int i = 0; i < r; i++) e[1151-8*i -: 8] = pad_q[b*r+i];
    return e;
  endfunction

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
  endtask

  task automatic load_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic send_word(input logic [63:0] w, input logic last, input logic [2:0] bn, input logic ack);
    word_v = w; is_last_v = last; bn_v = bn; f_ack_v = ack; in_ready_v = 1'b1;
    tick();
    in_ready_v = 1'b0; is_last_v = 1'b0; f_ack_v = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0; in_ready_v = 1'b1; f_ack_v = 1'b1; word_v = {$urandom, $urandom};
    tick();
    chk({tag, "_out32"}, if32.out, '0);
    chk({tag, "_rdy32"}, {1151'd0, if32.out_ready}, '0);
    chk({tag, "_full32"}, {1151'd0, if32.buffer_full}, '0);
    chk({tag, "_rsel32"}, {1150'd0, if32.rate_sel}, '0);
    chk({tag, "_out64"}, if64.out, '0);
    chk({tag, "_rdy64"}, {1151'd0, if64.out_ready}, '0);
    chk({tag, "_full64"}, {1151'd0, if64.buffer_full}, '0);
    reset = 1'b1; in_ready_v = 1'b0; f_ack_v = 1'b0;
  endtask

  task automatic finish_block(input string tag, input int b, input int r, input logic last, input logic [1:0] m);
    logic [1151:0] e;
    e = exp_block(b, r);
    chk({tag, "_rdy"}, {1151'd0, out_ready_o}, 1152'd1);
    chk({tag, "_full"}, {1151'd0, buffer_full_o}, 1152'd1);
    chk({tag, "_blk"}, out_o, e);
    // Word offered while waiting must be ignored.
    send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b0);
    chk({tag, "_hold"}, out_o, e);
    chk({tag, "_hold_rdy"}, {1151'd0, out_ready_o}, 1152'd1);
    // Ack together with a word: the word is dropped.
    send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b1);
    chk({tag, "_ack_rdy"}, {1151'd0, out_ready_o}, '0);
    chk({tag, "_ack_full"}, {1151'd0, buffer_full_o}, '0);
    chk({tag, "_ack_out"}, out_o, '0);
    if (last) begin
      send_word({$urandom, $urandom}, 1'b1, 3'd0, 1'b1);
      send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b0);
      chk({tag, "_done_out"}, out_o, '0);
      chk({tag, "_done_rdy"}, {1151'd0, out_ready_o}, '0);
      chk({tag, "_done_rsel"}, {1150'd0, rate_sel_o}, {1150'd0, m});
    end
  endtask

  task automatic run_msg(input string tag, input logic s64, input logic [1:0] m, input logic km);
    int nb, r, wpb, idx, slot, b, rem;
    logic first;
    logic [63:0] w;
    nb = s64 ? 8 : 4;
    r = rate_bytes(m);
    wpb = r / nb;
    build_pad(km, r);
    sel64 = s64; mode_v = m; kmode_v = km;
    idx = 0; slot = 0; b = 0; first = 1'b1;
    while (1) begin
      rem = msg_q.size() - idx;
      w = {$urandom, $urandom};
      if (rem >= nb) begin
        for (int j = 0; j < nb; j++) w[63-8*j -: 8] = msg_q[idx+j];
        send_word(w, 1'b0, 3'd0, 1'($urandom));
        idx += nb; slot++;
        if (first) begin
          chk({tag, "_rsel"}, {1150'd0, rate_sel_o}, {1150'd0, m});
          mode_v = ~m; first = 1'b0;
        end
        if (slot == wpb) begin
          finish_block(tag, b, r, 1'b0, m);
          b++; slot = 0;
        end else begin
          chk({tag, "_notfull"}, {1151'd0, buffer_full_o}, '0);
        end
      end else begin
        for (int j = 0; j < rem; j++) w[63-8*j -: 8] = msg_q[idx+j];
        send_word(w, 1'b1, 3'(rem), 1'($urandom));
        if (first) chk({tag, "_rsel"}, {1150'd0, rate_sel_o}, {1150'd0, m});
        finish_block(tag, b, r, 1'b1, m);
        break;
      end
    end
    $display("msg %s: sel64=%0d mode=%0d keccak=%0d len=%0d blocks=%0d", tag, s64, m, km, msg_q.size(), b + 1);
  endtask

  initial begin
    sel64 = 1'b0; mode_v = 2'd0; kmode_v = 1'b0; word_v = '0;
    in_ready_v = 1'b0; is_last_v = 1'b0; f_ack_v = 1'b0; bn_v = '0;
    do_reset("rst0");

    load_str("abc");
    run_msg("sha3_abc", 1'b0, 2'd3, 1'b0);
    do_reset("rst1");

    msg_q.delete();
    run_msg("empty", 1'b0, 2'd0, 1'b0);
    do_reset("rst2");

    load_rand(135);
    run_msg("combined", 1'b0, 2'd1, 1'b0);
    do_reset("rst3");

    load_rand(80);
    run_msg("multiblk", 1'b0, 2'd3, 1'b0);
    do_reset("rst4");

    load_str("Hello, world");
    run_msg("keccak64", 1'b1, 2'd2, 1'b1);
    do_reset("rst5");

    // Reset after five absorbed words.
    sel64 = 1'b0; mode_v = 2'd1; kmode_v = 1'b0;
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b0);
    chk("mid_rsel", {1150'd0, rate_sel_o}, 1152'd1);
    do_reset("rst_mid");
    load_rand(50);
    run_msg("after_mid", 1'b0, 2'd2, 1'b0);
    do_reset("rst6");

    // Reset while waiting for the ack.
    sel64 = 1'b0; mode_v = 2'd3;
    for (int i = 0; i < 18; i++) send_word({$urandom, $urandom}, 1'b0, 3'd0, 1'b0);
    chk("wait_rdy", {1151'd0, out_ready_o}, 1152'd1);
    do_reset("rst_wait");
    load_rand(30);
    run_msg("after_wait", 1'b0, 2'd0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      do_reset("rst_rand");
      load_rand(int'($urandom_range(0, 300)));
      run_msg("rand", 1'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
